net_inject_adapter: RTL and testbench
=====================================

Name: net_inject_adapter

Overview:
- Per-terminal injection stage directly upstream of one ring-network input port (in_val/in_rdy/in_msg[i]).
- Accepts raw requests (dest + payload) from a terminal and builds full network messages: dest, src = own router id, opaque = rolling sequence tag.
- Buffers messages in a small FIFO and presents them to the ring with val/rdy.
- One instance per router; 8 instances in the standard build.

Parameters:
- p_payload_nbits, 32, payload width (p)
- p_opaque_nbits, 3, opaque/sequence-tag width (o)
- p_srcdest_nbits, 3, src/dest field width (s)
- p_router_id, 0, id inserted into the src field
- p_num_routers, 8, number of valid destinations (0..p_num_routers-1)
- p_num_entries, 4, FIFO depth; power of two, >=2
- c_net_msg_nbits, p+o+2s, message width m (derived; do not override)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- in_val  input  1  terminal request valid
- in_rdy  output  1  adapter can accept a request
- in_dest  input  s  destination router id
- in_payload  input  p  payload
- out_val  output  1  message valid to ring input port
- out_rdy  input  1  ring input port ready
- out_msg  output  m  message; layout {dest[m-1:m-s], src, opaque, payload[p-1:0]}
- occupancy  output  clog2(p_num_entries)+1  current FIFO entry count
- err_dest  output  1  sticky flag: out-of-range destination seen

Behaviour:
- Reset (reset==0, asynchronous), all outputs and state are cleared:
  - FIFO empty, occupancy=0, out_val=0, out_msg=0
  - seq tag=0, err_dest=0
  - in_rdy=0 while reset is asserted
- Assertion mid-operation discards all queued messages immediately. First acceptance is possible in the cycle after reset deasserts.
- Enqueue fires when in_val && in_rdy. Conditions:
  - in_rdy = (occupancy < p_num_entries); no full-bypass.
  - When full, in_rdy=0 even if out_rdy=1 in the same cycle.
- Dequeue fires when out_val && out_rdy.
  - out_val = (occupancy != 0); out_msg = head entry, registered.
  - There is no empty-bypass: minimum latency from in_val to out_val is 1 cycle.
- Simultaneous enqueue and dequeue when not full and not empty: occupancy is unchanged and FIFO order is preserved.
- Pointers wrap modulo p_num_entries.
- Message build on enqueue:
  - dest = in_dest, src = p_router_id[s-1:0], opaque = seq, payload = in_payload.
  - seq increments by 1 on each enqueued message and wraps modulo 2^o (7 -> 0 for o=3).
- Out-of-range destination (in_dest >= p_num_routers):
  - The request is still handshaken (in_rdy unaffected) but dropped.
  - Not queued, seq not incremented, occupancy unchanged.
  - err_dest is set on the next edge and stays 1 until reset.
- out_msg holds stable while out_val=1 && out_rdy=0.
- The ring may hold out_rdy low indefinitely; no timeout.
- No combinational path from out_rdy to in_rdy.

Optional Feature:
- Macro: NET_INJECT_LOOPBACK_EN
- Defined:
  - Extra ports lb_val (out, 1), lb_rdy (in, 1), lb_msg (out, m).
  - Requests with in_dest == p_router_id bypass the ring. They go to a single-entry loopback register presented on lb_val/lb_msg, with the same message format and seq consumed.
  - For such requests, in_rdy = loopback register empty, or lb_rdy asserted in the same cycle.
  - in_rdy therefore depends combinationally on in_dest.
  - Loopback and ring messages are independently ordered.
  - Reset clears lb_val.
- Undefined:
  - lb ports are absent.
  - Self-addressed messages are queued to the ring FIFO like any other.

Test Plan:
- Reset: hold reset=0 with in_val=1 -> in_rdy=0, out_val=0, occupancy=0, err_dest=0. Deassert -> in_rdy=1 next cycle.
- Fill/drain, router_id=2, out_rdy=0: send dest 5/payload 0xA0..0xA3 -> in_rdy=0 after 4, occupancy=4. Then raise out_rdy -> out_msg dest=5, src=2, opaque 0,1,2,3 in order.
- Seq wrap: send 10 back-to-back messages with out_rdy=1 -> opaque 0..7,0,1; out_val first high 1 cycle after first in_val.
- Concurrent enq/deq at occupancy=2 for 5 cycles -> occupancy stays 2, payloads FIFO-ordered. At full with out_rdy=1 -> in_rdy=0 that cycle, occupancy 3 next.
- Bad dest, p_num_routers=6: send dest 6 then dest 1 -> only dest 1 appears, with opaque=0; err_dest=1 and sticky. Reset mid-stream with 3 queued -> out_val=0 immediately.
- Loopback (NET_INJECT_LOOPBACK_EN, router_id=3), lb_rdy=0: send dest 3, then dest 3 again -> lb_msg opaque=0, second request stalls (in_rdy=0). Ring request dest 4 still accepted, opaque=1.

Source files
------------

// File: rtl/net_inject_adapter_if.sv
// Terminal-request and ring-message val/rdy bundle around one net_inject_adapter.
// master = terminal/ring side, slave = adapter side.
interface net_inject_adapter_if #(
   parameter int p_payload_nbits = 32,
   parameter int p_opaque_nbits  = 3,
   parameter int p_srcdest_nbits = 3
);
   localparam int c_net_msg_nbits = p_payload_nbits + p_opaque_nbits + 2 * p_srcdest_nbits;

   logic                       in_val;
   logic                       in_rdy;
   logic [p_srcdest_nbits-1:0] in_dest;
   logic [p_payload_nbits-1:0] in_payload;
   logic                       out_val;
   logic                       out_rdy;
   logic [c_net_msg_nbits-1:0] out_msg;

   modport master (
      output in_val, in_dest, in_payload, out_rdy,
      input  in_rdy, out_val, out_msg
   );

   modport slave (
      input  in_val, in_dest, in_payload, out_rdy,
      output in_rdy, out_val, out_msg
   );
endinterface

// File: rtl/net_inject_adapter.sv
// Per-terminal injection stage: builds {dest,src,seq,payload} messages and queues them for the ring.
// Optional feature macro NET_INJECT_LOOPBACK_EN adds a single-entry loopback path for self-addressed requests.
module net_inject_adapter #(
   parameter int  p_payload_nbits = 32,
   parameter int  p_opaque_nbits  = 3,
   parameter int  p_srcdest_nbits = 3,
   parameter int  p_router_id     = 0,
   parameter int  p_num_routers   = 8,
   parameter int  p_num_entries   = 4,
   localparam int c_net_msg_nbits = p_payload_nbits + p_opaque_nbits + 2 * p_srcdest_nbits,
   localparam int c_occ_nbits     = $clog2(p_num_entries) + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   net_inject_adapter_if.slave        bus,
   output logic [c_occ_nbits-1:0]     occupancy,
   output logic                       err_dest
`ifdef NET_INJECT_LOOPBACK_EN
   ,
   output logic                       lb_val,
   input  logic                       lb_rdy,
   output logic [c_net_msg_nbits-1:0] lb_msg
`endif
);
   localparam int c_ptr_nbits = $clog2(p_num_entries);
   localparam logic [p_srcdest_nbits-1:0] c_src         = p_srcdest_nbits'(p_router_id);
   localparam logic [p_srcdest_nbits:0]   c_num_routers = (p_srcdest_nbits + 1)'(p_num_routers);
   localparam logic [c_occ_nbits-1:0]     c_depth       = c_occ_nbits'(p_num_entries);
   localparam logic [c_occ_nbits-1:0]     c_occ_zero    = {c_occ_nbits{1'b0}};
   localparam logic [c_occ_nbits-1:0]     c_occ_one     = c_occ_nbits'(1);
   localparam logic [c_ptr_nbits-1:0]     c_ptr_zero    = {c_ptr_nbits{1'b0}};
   localparam logic [c_ptr_nbits-1:0]     c_ptr_one     = c_ptr_nbits'(1);
   localparam logic [p_opaque_nbits-1:0]  c_seq_zero    = {p_opaque_nbits{1'b0}};
   localparam logic [p_opaque_nbits-1:0]  c_seq_one     = p_opaque_nbits'(1);
   localparam logic [c_net_msg_nbits-1:0] c_msg_zero    = {c_net_msg_nbits{1'b0}};

   logic [c_net_msg_nbits-1:0] mem_r [p_num_entries];
   logic [c_ptr_nbits-1:0]     wr_ptr_r;
   logic [c_ptr_nbits-1:0]     rd_ptr_r;
   logic [c_occ_nbits-1:0]     occ_r;
   logic [p_opaque_nbits-1:0]  seq_r;
   logic [c_net_msg_nbits-1:0] out_msg_r;
   logic                       out_val_r;
   logic                       ring_rdy_r;
   logic                       err_r;

   logic                       bad_dest_s;
   logic                       self_s;
   logic                       in_rdy_s;
   logic                       in_fire_s;
   logic                       enq_s;
   logic                       lb_enq_s;
   logic                       deq_s;
   logic [c_net_msg_nbits-1:0] new_msg_s;
   logic [c_occ_nbits-1:0]     occ_nxt_s;
   logic [c_net_msg_nbits-1:0] head_nxt_s;

`ifdef NET_INJECT_LOOPBACK_EN
   logic                       live_r;
   logic                       lb_val_r;
   logic [c_net_msg_nbits-1:0] lb_msg_r;
`endif

   // Request classification, handshakes, next occupancy and next head-of-queue.
   always_comb begin
      bad_dest_s = ({1'b0, bus.in_dest} >= c_num_routers);
`ifdef NET_INJECT_LOOPBACK_EN
      self_s = (bus.in_dest == c_src) && !bad_dest_s;
      if (self_s) begin
         in_rdy_s = live_r && (!lb_val_r || lb_rdy);
      end else begin
         in_rdy_s = ring_rdy_r;
      end
`else
      self_s   = 1'b0;
      in_rdy_s = ring_rdy_r;
`endif
      in_fire_s = bus.in_val && in_rdy_s;
      enq_s     = in_fire_s && !bad_dest_s && !self_s;
      lb_enq_s  = in_fire_s && !bad_dest_s && self_s;
      deq_s     = out_val_r && bus.out_rdy;
      new_msg_s = {bus.in_dest, c_src, seq_r, bus.in_payload};
      case ({enq_s, deq_s})
         2'b10:   occ_nxt_s = occ_r + c_occ_one;
         2'b01:   occ_nxt_s = occ_r - c_occ_one;
         default: occ_nxt_s = occ_r;
      endcase
      // The incoming message becomes head only when it lands in an empty (or emptying) queue.
      if (enq_s && ((occ_r == c_occ_zero) || (deq_s && (occ_r == c_occ_one)))) begin
         head_nxt_s = new_msg_s;
      end else if (deq_s) begin
         head_nxt_s = mem_r[rd_ptr_r + c_ptr_one];
      end else begin
         head_nxt_s = out_msg_r;
      end
   end

   // FIFO storage, pointers, sequence tag, sticky error and registered ring-side outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < p_num_entries; i++) begin
            mem_r[i] <= c_msg_zero;
         end
         wr_ptr_r   <= c_ptr_zero;
         rd_ptr_r   <= c_ptr_zero;
         occ_r      <= c_occ_zero;
         seq_r      <= c_seq_zero;
         out_msg_r  <= c_msg_zero;
         out_val_r  <= 1'b0;
         ring_rdy_r <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         if (enq_s) begin
            mem_r[wr_ptr_r] <= new_msg_s;
            wr_ptr_r        <= wr_ptr_r + c_ptr_one;
         end
         if (deq_s) begin
            rd_ptr_r <= rd_ptr_r + c_ptr_one;
         end
         if (enq_s || lb_enq_s) begin
            seq_r <= seq_r + c_seq_one;
         end
         if (in_fire_s && bad_dest_s) begin
            err_r <= 1'b1;
         end
         occ_r      <= occ_nxt_s;
         out_msg_r  <= head_nxt_s;
         out_val_r  <= (occ_nxt_s != c_occ_zero);
         ring_rdy_r <= (occ_nxt_s < c_depth);
      end
   end

`ifdef NET_INJECT_LOOPBACK_EN
   // Single-entry loopback register; live_r keeps self-addressed requests blocked during reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         live_r   <= 1'b0;
         lb_val_r <= 1'b0;
         lb_msg_r <= c_msg_zero;
      end else begin
         live_r <= 1'b1;
         if (lb_enq_s) begin
            lb_val_r <= 1'b1;
            lb_msg_r <= new_msg_s;
         end else if (lb_val_r && lb_rdy) begin
            lb_val_r <= 1'b0;
         end
      end
   end

   assign lb_val = lb_val_r;
   assign lb_msg = lb_msg_r;
`endif

   assign bus.in_rdy  = in_rdy_s;
   assign bus.out_val = out_val_r;
   assign bus.out_msg = out_msg_r;
   assign occupancy   = occ_r;
   assign err_dest    = err_r;
endmodule

// File: tb/tb_net_inject_adapter.sv
// Scoreboard bench for net_inject_adapter: directed scenarios plus randomized traffic against a queue model.
module tb_net_inject_adapter;
   localparam int P   = 32;
   localparam int O   = 3;
   localparam int S   = 3;
   localparam int RID = 2;
   localparam int NR  = 6;
   localparam int NE  = 4;
   localparam int M   = P + O + 2 * S;

   logic       clk;
   logic       reset;
   logic [2:0] occupancy;
   logic       err_dest;

   net_inject_adapter_if #(.p_payload_nbits(P), .p_opaque_nbits(O), .p_srcdest_nbits(S)) bus ();

`ifdef NET_INJECT_LOOPBACK_EN
   logic         lb_val;
   logic         lb_rdy;
   logic [M-1:0] lb_msg;
`endif

   net_inject_adapter #(
      .p_payload_nbits(P), .p_opaque_nbits(O), .p_srcdest_nbits(S),
      .p_router_id(RID), .p_num_routers(NR), .p_num_entries(NE)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .occupancy(occupancy), .err_dest(err_dest)
`ifdef NET_INJECT_LOOPBACK_EN
      , .lb_val(lb_val), .lb_rdy(lb_rdy), .lb_msg(lb_msg)
`endif
   );

   logic [M-1:0] ring_q [$];
   logic [M-1:0] lb_q [$];
   int           mdl_seq;
   bit           mdl_err;
   bit           mdl_alive;
   int           checks;
   int           errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: apply one accepted terminal request.
   task automatic model_accept(input logic [S-1:0] d, input logic [P-1:0] p);
      logic [M-1:0] m;
      m = {d, S'(RID), O'(mdl_seq), p};
      if (int'(d) >= NR) mdl_err = 1'b1;
`ifdef NET_INJECT_LOOPBACK_EN
      else if (int'(d) == RID) begin
         lb_q.push_back(m);
         mdl_seq = (mdl_seq + 1) % (1 << O);
      end
`endif
      else begin
         ring_q.push_back(m);
         mdl_seq = (mdl_seq + 1) % (1 << O);
      end
   endtask

   // Monitor: compare DUT outputs with the model and retire messages on each handshake.
   always @(negedge clk) begin
      if (reset) begin
         bit self_req;
         self_req = 1'b0;
`ifdef NET_INJECT_LOOPBACK_EN
         self_req = (int'(bus.in_dest) == RID);
         chk("lb_val", 64'(lb_val), 64'(lb_q.size() != 0));
         if (self_req) chk("in_rdy_lb", 64'(bus.in_rdy), 64'(mdl_alive && (lb_q.size() == 0 || lb_rdy)));
         if (lb_q.size() != 0) begin
            chk("lb_msg", 64'(lb_msg), 64'(lb_q[0]));
            if (lb_rdy) void'(lb_q.pop_front());
         end
`endif
         chk("occupancy", 64'(occupancy), 64'(ring_q.size()));
         chk("out_val", 64'(bus.out_val), 64'(ring_q.size() != 0));
         chk("err_dest", 64'(err_dest), 64'(mdl_err));
         if (!self_req) chk("in_rdy", 64'(bus.in_rdy), 64'(mdl_alive && (ring_q.size() < NE)));
         if (ring_q.size() != 0) begin
            chk("out_msg", 64'(bus.out_msg), 64'(ring_q[0]));
            if (bus.out_rdy) void'(ring_q.pop_front());
         end
         mdl_alive = 1'b1;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one request until accepted; starts and ends just after a rising edge.
   task automatic send(input logic [S-1:0] d, input logic [P-1:0] p);
      bit done;
      done = 1'b0;
      bus.in_val = 1'b1;
      bus.in_dest = d;
      bus.in_payload = p;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         #2;
         if (bus.in_rdy) begin
            model_accept(d, p);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_val = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: dest %0d not accepted in 40 cycles, expected acceptance", d);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      ring_q.delete();
      lb_q.delete();
      mdl_seq = 0;
      mdl_err = 1'b0;
      mdl_alive = 1'b0;
      #1;
      chk("rst_out_val", 64'(bus.out_val), 64'd0);
      chk("rst_occ", 64'(occupancy), 64'd0);
      @(negedge clk);
      chk("rst_in_rdy", 64'(bus.in_rdy), 64'd0);
      chk("rst_out_msg", 64'(bus.out_msg), 64'd0);
      chk("rst_err", 64'(err_dest), 64'd0);
      @(posedge clk);
      #1;
      bus.in_val = 1'b0;
      reset = 1'b1;
   endtask

   task automatic drain();
      bus.out_rdy = 1'b1;
      for (int i = 0; i < 60 && (ring_q.size() != 0 || lb_q.size() != 0); i++) wait_cycles(1);
      chk("drain_empty", 64'(ring_q.size() + lb_q.size()), 64'd0);
   endtask

   task automatic rand_cycles(input int n, input int rdy_pct);
      for (int c = 0; c < n; c++) begin
         bus.in_val = ($urandom_range(0, 2) != 0);
         bus.in_dest = S'($urandom_range(0, 7));
         bus.in_payload = $urandom;
         bus.out_rdy = ($urandom_range(1, 100) <= rdy_pct);
         @(negedge clk);
         #2;
         if (bus.in_val && bus.in_rdy) model_accept(bus.in_dest, bus.in_payload);
         @(posedge clk);
         #1;
      end
      bus.in_val = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      bus.in_val = 1'b1;
      bus.in_dest = 3'd5;
      bus.in_payload = 32'h0;
      bus.out_rdy = 1'b0;
`ifdef NET_INJECT_LOOPBACK_EN
      lb_rdy = 1'b1;
`endif
      @(posedge clk);
      #1;
      // Reset held with in_val high, then release.
      do_reset();
      wait_cycles(1);
      chk("rdy_after_reset", 64'(bus.in_rdy), 64'd1);

      // Fill with the ring stalled, then drain in order.
      for (int i = 0; i < 4; i++) send(3'd5, P'(32'hA0 + i));
      chk("fill_occ", 64'(occupancy), 64'd4);
      chk("fill_rdy", 64'(bus.in_rdy), 64'd0);
      drain();

      // Ten back-to-back messages: sequence tag wraps 7 -> 0.
      do_reset();
      wait_cycles(1);
      bus.out_rdy = 1'b1;
      send(3'd4, 32'hB0);
      chk("latency_out_val", 64'(bus.out_val), 64'd1);
      for (int i = 1; i < 10; i++) send(S'(i % 6), P'(32'hB0 + i));
      drain();

      // Concurrent enqueue/dequeue at occupancy 2, then full with out_rdy high.
      do_reset();
      bus.out_rdy = 1'b0;
      send(3'd1, 32'hC0);
      send(3'd1, 32'hC1);
      chk("conc_occ_start", 64'(occupancy), 64'd2);
      bus.out_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(3'd0, P'(32'hC2 + i));
         chk("conc_occ", 64'(occupancy), 64'd2);
      end
      bus.out_rdy = 1'b0;
      send(3'd3, 32'hD0);
      send(3'd3, 32'hD1);
      chk("full_occ", 64'(occupancy), 64'd4);
      bus.out_rdy = 1'b1;
      bus.in_val = 1'b1;
      bus.in_dest = 3'd3;
      bus.in_payload = 32'hD2;
      @(negedge clk);
      #2;
      chk("full_in_rdy", 64'(bus.in_rdy), 64'd0);
      @(posedge clk);
      #1;
      bus.in_val = 1'b0;
      chk("full_occ_next", 64'(occupancy), 64'd3);
      drain();

      // Out-of-range destination dropped, error sticky; reset discards queue.
      do_reset();
      bus.out_rdy = 1'b1;
      send(3'd6, 32'hE0);
      send(3'd1, 32'hE1);
      wait_cycles(4);
      chk("err_sticky", 64'(err_dest), 64'd1);
      bus.out_rdy = 1'b0;
      send(3'd0, 32'hE2);
      send(3'd4, 32'hE3);
      send(3'd5, 32'hE4);
      chk("pre_reset_occ", 64'(occupancy), 64'd3);
      do_reset();

      // Randomized traffic with a mostly-ready and a mostly-stalled ring.
      wait_cycles(1);
      rand_cycles(1500, 75);
      rand_cycles(800, 20);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
